// File: rtl/dvi_pkg.sv
// Shared TMDS definitions: control tokens, symbol type, encoding modes and
// small combinational helpers used by every DVI channel encoder.
package dvi_pkg;

  typedef logic [9:0] tmds_symbol_t;

  localparam tmds_symbol_t CTL_TOKEN_00 = 10'b1101010100;
  localparam tmds_symbol_t CTL_TOKEN_01 = 10'b0010101011;
  localparam tmds_symbol_t CTL_TOKEN_10 = 10'b0101010100;
  localparam tmds_symbol_t CTL_TOKEN_11 = 10'b1010101011;

  // Stage-2 symbol selection, one per DC-balance decision branch
  typedef enum logic [1:0] {
    ENC_CTRL    = 2'd0,
    ENC_BALANCE = 2'd1,
    ENC_INVERT  = 2'd2,
    ENC_PASS    = 2'd3
  } enc_mode_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic tmds_symbol_t ctl_token(input logic [1:0] c);
    tmds_symbol_t t;
    unique case (c)
      2'b00:   t = CTL_TOKEN_00;
      2'b01:   t = CTL_TOKEN_01;
      2'b10:   t = CTL_TOKEN_10;
      default: t = CTL_TOKEN_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One DVI TMDS channel: stage 1 transition-minimising 8->9 bit coding,
// stage 2 DC-balancing 9->10 bit coding with a signed running disparity.
module tmds_channel_encoder
  import dvi_pkg::*;
#(
  parameter int CNT_WIDTH = 5
) (
  input  logic       clk_rgb,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [7:0] d,
  input  logic [1:0] c,
  input  logic       de,
  output logic [9:0] q
);

  localparam logic signed [CNT_WIDTH-1:0] TWO     = CNT_WIDTH'(2);
  localparam logic signed [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(10);
  localparam logic signed [CNT_WIDTH-1:0] CNT_MIN = -CNT_MAX;

  // Stage 1: 8 -> 9 bit transition minimisation
  logic [3:0] n1_d;
  logic       use_xnor;
  logic [8:0] q_m_d;

  always_comb begin
    n1_d     = popcount8(d);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
    q_m_d    = '0;
    q_m_d[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ d[i]) : (q_m_d[i-1] ^ d[i]);
    end
    q_m_d[8] = ~use_xnor;
  end

  logic [8:0] q_m_r;
  logic       de_r;
  logic [1:0] c_r;

  always_ff @(posedge clk_rgb or negedge rst_n) begin
    if (!rst_n) begin
      q_m_r <= '0;
      de_r  <= 1'b0;
      c_r   <= '0;
    end else if (ce) begin
      q_m_r <= q_m_d;
      de_r  <= de;
      c_r   <= c;
    end
  end

  // Stage 2: DC balance against the running disparity
  logic [3:0]                  n1_q;
  logic signed [CNT_WIDTH-1:0] diff;
  logic signed [CNT_WIDTH-1:0] cnt;
  logic signed [CNT_WIDTH-1:0] cnt_nxt;
  logic                        cnt_pos, cnt_neg, diff_pos, diff_neg;
  enc_mode_t                   mode;
  tmds_symbol_t                q_nxt;

  always_comb begin
    n1_q     = popcount8(q_m_r[7:0]);
    // N1 - N0 == 2*N1 - 8, taken modulo 2^CNT_WIDTH
    diff     = CNT_WIDTH'({n1_q, 1'b0}) - CNT_WIDTH'(8);
    cnt_neg  = cnt[CNT_WIDTH-1];
    cnt_pos  = !cnt[CNT_WIDTH-1] && (cnt != '0);
    diff_neg = diff[CNT_WIDTH-1];
    diff_pos = !diff[CNT_WIDTH-1] && (diff != '0);

    if (!de_r) begin
      mode = ENC_CTRL;
    end else if ((cnt == '0) || (diff == '0)) begin
      mode = ENC_BALANCE;
    end else if ((cnt_pos && diff_pos) || (cnt_neg && diff_neg)) begin
      mode = ENC_INVERT;
    end else begin
      mode = ENC_PASS;
    end

    q_nxt   = ctl_token(c_r);
    cnt_nxt = '0;
    unique case (mode)
      ENC_CTRL: begin
        q_nxt   = ctl_token(c_r);
        cnt_nxt = '0;
      end
      ENC_BALANCE: begin
        q_nxt   = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
        cnt_nxt = q_m_r[8] ? (cnt + diff) : (cnt - diff);
      end
      ENC_INVERT: begin
        q_nxt   = {1'b1, q_m_r[8], ~q_m_r[7:0]};
        cnt_nxt = cnt - diff + (q_m_r[8] ? TWO : '0);
      end
      default: begin
        q_nxt   = {1'b0, q_m_r[8], q_m_r[7:0]};
        cnt_nxt = cnt + diff - (q_m_r[8] ? '0 : TWO);
      end
    endcase
  end

  always_ff @(posedge clk_rgb or negedge rst_n) begin
    if (!rst_n) begin
      q   <= CTL_TOKEN_00;
      cnt <= '0;
    end else if (ce) begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Any value outside +/-10 means the balance rules were broken upstream
  cnt_in_range_a: assert property (@(posedge clk_rgb) disable iff (!rst_n)
                                   (cnt >= CNT_MIN) && (cnt <= CNT_MAX));

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: three independent channel encoders, 2-cycle latency;
// sync polarity option and control mapping (hs/vs only on blue channel).
module dvi_tmds_encoder
  import dvi_pkg::*;
#(
  parameter int   CNT_WIDTH          = 5,
  parameter logic SYNC_POLARITY_PASS = 1'b1
) (
  input  logic       clk_rgb,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  input  logic       hs,
  input  logic       vs,
  input  logic       de,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2
);

  logic [1:0] sync_c;

  always_comb begin
    sync_c = SYNC_POLARITY_PASS ? {vs, hs} : ~{vs, hs};
  end

  tmds_channel_encoder #(.CNT_WIDTH(CNT_WIDTH)) u_ch0 (
    .clk_rgb (clk_rgb),
    .rst_n   (rst_n),
    .ce      (ce),
    .d       (b),
    .c       (sync_c),
    .de      (de),
    .q       (tmds_ch0)
  );

  tmds_channel_encoder #(.CNT_WIDTH(CNT_WIDTH)) u_ch1 (
    .clk_rgb (clk_rgb),
    .rst_n   (rst_n),
    .ce      (ce),
    .d       (g),
    .c       (2'b00),
    .de      (de),
    .q       (tmds_ch1)
  );

  tmds_channel_encoder #(.CNT_WIDTH(CNT_WIDTH)) u_ch2 (
    .clk_rgb (clk_rgb),
    .rst_n   (rst_n),
    .ce      (ce),
    .d       (r),
    .c       (2'b00),
    .de      (de),
    .q       (tmds_ch2)
  );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Self-checking bench for dvi_tmds_encoder: directed steps plus random bursts,
// scoreboard of model-predicted symbols compared two ce-cycles later.
module tb_dvi_tmds_encoder;

  logic       clk_rgb = 1'b0;
  logic       rst_n   = 1'b1;
  logic       ce      = 1'b1;
  logic [7:0] r = '0, g = '0, b = '0;
  logic       hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;

  dvi_tmds_encoder #(.CNT_WIDTH(5), .SYNC_POLARITY_PASS(1'b1)) u_dut (
    .clk_rgb  (clk_rgb),
    .rst_n    (rst_n),
    .ce       (ce),
    .r        (r),
    .g        (g),
    .b        (b),
    .hs       (hs),
    .vs       (vs),
    .de       (de),
    .tmds_ch0 (tmds_ch0),
    .tmds_ch1 (tmds_ch1),
    .tmds_ch2 (tmds_ch2)
  );

  always #5 clk_rgb = ~clk_rgb;

  typedef struct {
    logic [9:0] s0, s1, s2;
    int         cnt0;
    logic       de;
    logic [7:0] d0, d1, d2;
  } sb_t;

  sb_t sb[$];
  sb_t last;
  int  m_cnt0, m_cnt1, m_cnt2;
  int  checks = 0;
  int  errors = 0;

  logic [9:0] exp00 [4] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
  int         cnt00 [4] = '{-8, 2, -6, 4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ref_enc(input logic [7:0] d, input logic [1:0] c,
                                         input logic den, input int cnt_i, output int cnt_o);
    logic [8:0] qm;
    logic       xn;
    int         n1, n0;
    if (!den) begin
      cnt_o = 0;
      case (c)
        2'b00:   return 10'b1101010100;
        2'b01:   return 10'b0010101011;
        2'b10:   return 10'b0101010100;
        default: return 10'b1010101011;
      endcase
    end
    n1    = $countones(d);
    xn    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (cnt_i == 0 || n1 == n0) begin
      cnt_o = qm[8] ? cnt_i + n1 - n0 : cnt_i + n0 - n1;
      return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
    end else if ((cnt_i > 0 && n1 > n0) || (cnt_i < 0 && n0 > n1)) begin
      cnt_o = cnt_i + 2 * int'(qm[8]) + n0 - n1;
      return {1'b1, qm[8], ~qm[7:0]};
    end else begin
      cnt_o = cnt_i + n1 - n0 - 2 * int'(!qm[8]);
      return {1'b0, qm[8], qm[7:0]};
    end
  endfunction

  function automatic logic [7:0] ref_dec(input logic [9:0] s);
    logic [7:0] w, o;
    w    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = w[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return o;
  endfunction

  task automatic prime_after_reset();
    sb_t p;
    sb.delete();
    m_cnt0 = 0; m_cnt1 = 0; m_cnt2 = 0;
    p.s0 = 10'h354; p.s1 = 10'h354; p.s2 = 10'h354;
    p.cnt0 = 0; p.de = 1'b0; p.d0 = '0; p.d1 = '0; p.d2 = '0;
    sb.push_back(p);
    last = p;
  endtask

  task automatic check_entry(input sb_t e);
    int c0;
    c0 = int'(u_dut.u_ch0.cnt);
    chk("sb_ch0", tmds_ch0, e.s0);
    chk("sb_ch1", tmds_ch1, e.s1);
    chk("sb_ch2", tmds_ch2, e.s2);
    chk("sb_cnt0", c0, e.cnt0);
    chk("cnt0_range", 32'((c0 >= -10) && (c0 <= 10)), 32'd1);
    if (e.de) begin
      chk("dec_ch0", ref_dec(tmds_ch0), e.d0);
      chk("dec_ch1", ref_dec(tmds_ch1), e.d1);
      chk("dec_ch2", ref_dec(tmds_ch2), e.d2);
    end
  endtask

  task automatic cycle(input logic [7:0] ri, gi, bi, input logic hsi, vsi, dei, cei);
    sb_t e;
    int  nc;
    r = ri; g = gi; b = bi; hs = hsi; vs = vsi; de = dei; ce = cei;
    if (cei) begin
      e.s0 = ref_enc(bi, {vsi, hsi}, dei, m_cnt0, nc); m_cnt0 = nc; e.cnt0 = nc;
      e.s1 = ref_enc(gi, 2'b00, dei, m_cnt1, nc);      m_cnt1 = nc;
      e.s2 = ref_enc(ri, 2'b00, dei, m_cnt2, nc);      m_cnt2 = nc;
      e.de = dei; e.d0 = bi; e.d1 = gi; e.d2 = ri;
      sb.push_back(e);
    end
    @(posedge clk_rgb);
    #1;
    if (cei) begin
      chk("sb_depth", 32'(sb.size() >= 2), 32'd1);
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        check_entry(e);
        last = e;
      end
    end else begin
      chk("hold_ch0", tmds_ch0, last.s0);
      chk("hold_ch1", tmds_ch1, last.s1);
      chk("hold_ch2", tmds_ch2, last.s2);
      chk("hold_cnt0", int'(u_dut.u_ch0.cnt), last.cnt0);
    end
  endtask

  task automatic rnd_pix(input logic dei, input logic cei);
    cycle(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), dei, cei);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic de_s;
    // Reset held: tokens and cleared counter
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk_rgb);
    #1;
    chk("rst_ch0", tmds_ch0, 10'h354);
    chk("rst_ch1", tmds_ch1, 10'h354);
    chk("rst_ch2", tmds_ch2, 10'h354);
    chk("rst_cnt0", int'(u_dut.u_ch0.cnt), 0);
    rst_n = 1'b1;
    prime_after_reset();

    // hs=1 control token on ch0 two cycles later
    cycle(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("hs_ch0", tmds_ch0, 10'h0AB);
    chk("hs_ch1", tmds_ch1, 10'h354);
    chk("hs_ch2", tmds_ch2, 10'h354);
    cycle(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

    // b=00 run from cnt=0: alternating symbols and disparity
    cycle(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("b00_sym", tmds_ch0, exp00[i]);
      chk("b00_cnt", int'(u_dut.u_ch0.cnt), cnt00[i]);
    end
    // first blanking cycle emits a token despite nonzero disparity
    cycle(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("blank_ch0", tmds_ch0, 10'h354);
    chk("blank_cnt0", int'(u_dut.u_ch0.cnt), 0);

    // b=FF from cnt=0
    cycle(8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bff_sym", tmds_ch0, 10'h200);
    chk("bff_cnt", int'(u_dut.u_ch0.cnt), -8);

    // ce freeze mid-line with changing inputs
    repeat (4) rnd_pix(1'b1, 1'b1);
    repeat (5) rnd_pix(1'b1, 1'b0);
    repeat (6) rnd_pix(1'b1, 1'b1);

    // async reset mid-pixel, de active
    repeat (3) rnd_pix(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ch0", tmds_ch0, 10'h354);
    chk("arst_ch1", tmds_ch1, 10'h354);
    chk("arst_ch2", tmds_ch2, 10'h354);
    chk("arst_cnt0", int'(u_dut.u_ch0.cnt), 0);
    @(posedge clk_rgb);
    #1 rst_n = 1'b1;
    prime_after_reset();
    repeat (6) rnd_pix(1'b1, 1'b1);

    // random pixels with de bursts and occasional ce drops
    de_s = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) de_s = ~de_s;
      rnd_pix(de_s, ($urandom_range(0, 15) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
